// File: rtl/muldiv_pkg.sv
// Shared constants and types for the multi-cycle MULT/DIV sequencer.
package muldiv_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CNT_W = 6;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_ZERO = 2'd3;

  // Operation context captured at start and held until the result is written.
  typedef struct packed {
    logic op;
    logic sign_a;
    logic sign_b;
  } op_ctx_t;

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Control-unit <-> MULT/DIV engine handshake and HI/LO result bus.
interface muldiv_sequencer_if #(parameter int WIDTH = 32);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             abort;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;

  modport master (output start, op, a_in, b_in, abort,
                  input  busy, done, div_zero, hi_out, lo_out);
  modport slave  (input  start, op, a_in, b_in, abort,
                  output busy, done, div_zero, hi_out, lo_out);
endinterface

// File: rtl/muldiv_sign_fix.sv
// Applies operand signs to the unsigned magnitude result and produces HI/LO.
module muldiv_sign_fix import muldiv_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             op,
  input  logic             sign_a,
  input  logic             sign_b,
  input  logic [WIDTH-1:0] hi_raw,
  input  logic [WIDTH-1:0] lo_raw,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_neg;

  always_comb begin
    prod     = {hi_raw, lo_raw};
    prod_neg = -prod;
    hi       = hi_raw;
    lo       = lo_raw;
    if (op == OP_MULT) begin
      if (sign_a ^ sign_b) {hi, lo} = prod_neg;
    end else begin
      // Quotient follows sign(a)^sign(b); remainder follows the dividend.
      if (sign_a ^ sign_b) lo = -lo_raw;
      if (sign_a)          hi = -hi_raw;
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle signed MULT/DIV engine: one start, WIDTH iterations, sign fix, HI/LO write.
module muldiv_sequencer import muldiv_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic               clock,
  input  logic               reset,
  muldiv_sequencer_if.slave  bus
);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  op_ctx_t          ctx;
  logic             done_q;
  logic [WIDTH-1:0] hi_q, lo_q;

  // acc_hi: MULT upper partial product / DIV partial remainder.
  // acc_lo: MULT multiplier shift reg / DIV dividend-in, quotient-out.
  // opnd:   MULT |a| / DIV |b|; WIDTH+1 bits so |INT_MIN| is representable.
  logic [WIDTH:0]   acc_hi, opnd;
  logic [WIDTH-1:0] acc_lo;

  logic [WIDTH:0]   a_ext, b_ext, a_mag, b_mag;
  logic [WIDTH:0]   mul_sum, div_shift;
  logic [WIDTH+1:0] div_diff;
  logic [WIDTH-1:0] fix_hi, fix_lo;
  logic             last_iter;

  always_comb begin
    a_ext     = {bus.a_in[WIDTH-1], bus.a_in};
    b_ext     = {bus.b_in[WIDTH-1], bus.b_in};
    a_mag     = a_ext[WIDTH] ? -a_ext : a_ext;
    b_mag     = b_ext[WIDTH] ? -b_ext : b_ext;
    mul_sum   = acc_hi + (acc_lo[0] ? opnd : '0);
    div_shift = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
    div_diff  = {1'b0, div_shift} - {1'b0, opnd};
    last_iter = (cnt == CNT_W'(WIDTH - 1));
  end

  muldiv_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
    .op     (ctx.op),
    .sign_a (ctx.sign_a),
    .sign_b (ctx.sign_b),
    .hi_raw (acc_hi[WIDTH-1:0]),
    .lo_raw (acc_lo),
    .hi     (fix_hi),
    .lo     (fix_lo)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      ctx    <= '0;
      done_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      opnd   <= '0;
    end else begin
      done_q <= 1'b0;
      if (bus.abort) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: if (bus.start) begin
            if (bus.op == OP_DIV && bus.b_in == '0) begin
              state <= S_ZERO;
            end else begin
              state  <= S_RUN;
              cnt    <= '0;
              ctx    <= '{op: bus.op, sign_a: bus.a_in[WIDTH-1], sign_b: bus.b_in[WIDTH-1]};
              acc_hi <= '0;
              opnd   <= (bus.op == OP_MULT) ? a_mag : b_mag;
              acc_lo <= (bus.op == OP_MULT) ? b_mag[WIDTH-1:0] : a_mag[WIDTH-1:0];
            end
          end
          S_RUN: begin
            if (ctx.op == OP_MULT) begin
              acc_hi <= {1'b0, mul_sum[WIDTH:1]};
              acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
            end else if (!div_diff[WIDTH+1]) begin
              acc_hi <= div_diff[WIDTH:0];
              acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
              acc_hi <= div_shift;
              acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
            end
            cnt <= cnt + 1'b1;
            if (last_iter) state <= S_FIX;
          end
          S_FIX: begin
            hi_q   <= fix_hi;
            lo_q   <= fix_lo;
            done_q <= 1'b1;
            state  <= S_IDLE;
          end
          S_ZERO:  state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.busy     = (state != S_IDLE);
  assign bus.div_zero = (state == S_ZERO);
  assign bus.done     = done_q;
  assign bus.hi_out   = hi_q;
  assign bus.lo_out   = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: behavioural signed model, latency and pulse checks.
module tb_muldiv_sequencer;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  exp_t sbq[$];
  exp_t mon_e;
  logic [W-1:0] last_hi = '0, last_lo = '0;
  logic prev_done = 1'b0, prev_dz = 1'b0;

  always #5 clk = ~clk;

  muldiv_sequencer_if #(.WIDTH(W)) bus ();

  muldiv_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic op, input logic [W-1:0] a, b,
                                output logic [W-1:0] hi, output logic [W-1:0] lo);
    longint p;
    int ia, ib;
    ia = a;
    ib = b;
    if (op == 1'b0) begin
      p  = longint'(ia) * longint'(ib);
      hi = p[63:32];
      lo = p[31:0];
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      hi = '0;
      lo = 32'h8000_0000;
    end else begin
      lo = ia / ib;
      hi = ia % ib;
    end
  endfunction

  // Result checks happen here whenever done fires, against the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.done || bus.div_zero)
        chk("pulse_excl", {61'd0, bus.done & bus.div_zero, bus.done & prev_done, bus.div_zero & prev_dz}, 64'd0);
      if (bus.done) begin
        if (sbq.size() == 0) chk("unexp_done", 64'd0, 64'd1);
        else begin
          mon_e = sbq.pop_front();
          chk("hi", bus.hi_out, mon_e.hi);
          chk("lo", bus.lo_out, mon_e.lo);
          last_hi = mon_e.hi;
          last_lo = mon_e.lo;
        end
      end
    end
    prev_done = bus.done;
    prev_dz   = bus.div_zero;
  end

  // Called at a negedge; start is sampled at the next posedge (edge N).
  task automatic issue(input logic op, input logic [W-1:0] a, b, input bit expect_done);
    exp_t e;
    if (expect_done) begin
      model(op, a, b, e.hi, e.lo);
      sbq.push_back(e);
    end
    bus.start = 1'b1;
    bus.op    = op;
    bus.a_in  = a;
    bus.b_in  = b;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  // Cycle k is the cycle following edge N+k-1; done is due in cycle 34.
  task automatic finish(input string tag, input int cyc0);
    int  cyc;
    bit  seen;
    cyc  = cyc0;
    seen = 1'b0;
    while (!seen && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (bus.done) seen = 1'b1;
    end
    if (!seen) chk({tag, "_timeout"}, 64'd0, 64'd1);
    else begin
      chk({tag, "_lat"}, cyc, 64'd34);
      chk({tag, "_busy_done"}, bus.busy, 64'd0);
    end
  endtask

  task automatic run_op(input string tag, input logic op, input logic [W-1:0] a, b);
    issue(op, a, b, 1'b1);
    @(negedge clk);
    chk({tag, "_busy1"}, bus.busy, 64'd1);
    finish(tag, 1);
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_busy"}, bus.busy, 64'd0);
    chk({tag, "_done"}, bus.done, 64'd0);
    chk({tag, "_dz"},   bus.div_zero, 64'd0);
    chk({tag, "_hi"},   bus.hi_out, 64'd0);
    chk({tag, "_lo"},   bus.lo_out, 64'd0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.op    = 1'b0;
    bus.a_in  = '0;
    bus.b_in  = '0;
    bus.abort = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle_zero("reset");
    rst = 1'b0;

    // 1: 7 * -3
    run_op("mul_7_m3", 1'b0, 32'd7, 32'hFFFF_FFFD);
    chk("t1_hi", bus.hi_out, 64'hFFFF_FFFF);
    chk("t1_lo", bus.lo_out, 64'hFFFF_FFEB);

    // 2: back-to-back divides
    run_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
    chk("t2a_lo", bus.lo_out, 64'hFFFF_FFFD);
    chk("t2a_hi", bus.hi_out, 64'hFFFF_FFFF);
    run_op("div_100_7", 1'b1, 32'd100, 32'd7);
    chk("t2b_lo", bus.lo_out, 64'd14);
    chk("t2b_hi", bus.hi_out, 64'd2);

    // 3: divide by zero
    issue(1'b1, 32'd55, 32'd0, 1'b0);
    @(negedge clk);
    chk("dz_pulse", bus.div_zero, 64'd1);
    chk("dz_busy",  bus.busy, 64'd1);
    @(negedge clk);
    chk("dz_clear", bus.div_zero, 64'd0);
    chk("dz_idle",  bus.busy, 64'd0);
    chk("dz_nodone", bus.done, 64'd0);
    chk("dz_hi", bus.hi_out, 64'd2);
    chk("dz_lo", bus.lo_out, 64'd14);

    // 4: INT_MIN corner cases
    run_op("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("t4a_lo", bus.lo_out, 64'h8000_0000);
    chk("t4a_hi", bus.hi_out, 64'd0);
    run_op("mul_min_min", 1'b0, 32'h8000_0000, 32'h8000_0000);
    chk("t4b_hi", bus.hi_out, 64'h4000_0000);
    chk("t4b_lo", bus.lo_out, 64'd0);

    // 5: abort in cycle N+10, then a normal op
    issue(1'b0, 32'd1234, 32'hFFFF_FFFB, 1'b1);
    repeat (10) @(negedge clk);
    bus.abort = 1'b1;
    void'(sbq.pop_back());
    @(posedge clk);
    #1 bus.abort = 1'b0;
    @(negedge clk);
    chk("abort_busy", bus.busy, 64'd0);
    chk("abort_done", bus.done, 64'd0);
    chk("abort_hi", bus.hi_out, {32'd0, last_hi});
    chk("abort_lo", bus.lo_out, {32'd0, last_lo});
    repeat (40) @(negedge clk);
    chk("abort_keep_hi", bus.hi_out, 64'h4000_0000);
    run_op("after_abort", 1'b1, 32'hFFFF_FF9C, 32'd7);

    // abort and start in the same idle cycle: start dropped
    bus.abort = 1'b1;
    issue(1'b0, 32'd3, 32'd3, 1'b0);
    bus.abort = 1'b0;
    @(negedge clk);
    chk("abort_start_busy", bus.busy, 64'd0);

    // 6: start during RUN ignored
    issue(1'b1, 32'd1000, 32'd7, 1'b1);
    repeat (4) @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 1'b0;
    bus.a_in  = 32'd3;
    bus.b_in  = 32'd3;
    @(posedge clk);
    #1 bus.start = 1'b0;
    finish("ign_start", 4);

    // reset mid-operation
    issue(1'b0, 32'd99, 32'd77, 1'b1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    void'(sbq.pop_back());
    @(posedge clk);
    #1 rst = 1'b0;
    last_hi = '0;
    last_lo = '0;
    @(negedge clk);
    chk_idle_zero("mid_rst");
    repeat (40) @(negedge clk);
    run_op("after_rst", 1'b0, 32'hFFFF_F000, 32'h0001_2345);

    // random operands, issued back to back
    for (int i = 0; i < 6; i++) begin
      logic [W-1:0] ra, rb;
      logic         rop;
      ra  = $urandom;
      rb  = $urandom;
      rop = i[0];
      if (rop && rb == '0) rb = 32'd1;
      if (i == 4) rb = rb >> 20;
      run_op("rand", rop, ra, rb);
    end

    repeat (3) @(negedge clk);
    chk("sb_empty", sbq.size(), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
